load_store_unit: RTL and testbench

Sits between the core datapath and the word-organised data memory, which supports only whole-word asynchronous reads and whole-word writes on a clock edge. Translates RISC-V-style byte, halfword and word loads and stores into word accesses. Loads are extracted and extended combinationally. Sub-word stores use a two-cycle read-modify-write sequence that stalls the core. Detects misaligned and illegal requests, suppresses them, and counts them.

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Maps byte/halfword/word loads and stores onto a word-only data
//             memory. Loads are combinational; SB/SH use a stalled two-cycle
//             read-modify-write. Misaligned or illegal requests are dropped
//             and counted in a saturating error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  input  logic [31:0]      mem_rdata,
  output logic             mem_read_flag,
  output logic             mem_write_flag,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      load_data,
  output logic             stall,
  output logic             fault,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic [31:0]      merge_q, merge_d;
  logic [31:0]      addr_q, addr_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [31:0]      aligned_addr;
  logic             load_ok;
  logic             store_ok;
  logic             misaligned;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Request classification and lane selection from the raw core inputs
  always_comb begin
    aligned_addr = {addr[31:2], 2'b00};
    load_ok      = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
    store_ok     = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    // H and HU share funct3[1:0]=01; only their low address bit matters
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    fault        = active_q && (state_q == IDLE) &&
                   ((is_load && is_store) ||
                    (is_load && !load_ok) ||
                    (is_store && !store_ok) ||
                    ((is_load || is_store) && misaligned));
    byte_sel     = mem_rdata[{addr[1:0], 3'b000} +: 8];
    half_sel     = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Next-state and output decode; active_q masks the reset-deassertion cycle
  always_comb begin
    state_d        = state_q;
    active_d       = 1'b1;
    merge_d        = merge_q;
    addr_d         = addr_q;
    err_d          = err_q;
    mem_read_flag  = 1'b0;
    mem_write_flag = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    load_data      = 32'h0;
    stall          = 1'b0;

    if (active_q) begin
      case (state_q)
        IDLE: begin
          if (fault) begin
            if (err_q != {ERR_W{1'b1}}) begin
              err_d = err_q + 1'b1;
            end
          end else if (is_load) begin
            mem_read_flag = 1'b1;
            mem_addr      = aligned_addr;
            case (funct3)
              F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
              F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
              F3_BU:   load_data = {24'h0, byte_sel};
              F3_HU:   load_data = {16'h0, half_sel};
              default: load_data = mem_rdata;
            endcase
          end else if (is_store) begin
            mem_addr = aligned_addr;
            if (funct3 == F3_W) begin
              mem_write_flag = 1'b1;
              mem_wdata      = store_data;
            end else begin
              // Read phase of read-modify-write: merge the new lane now
              mem_read_flag = 1'b1;
              stall         = 1'b1;
              merge_d       = mem_rdata;
              if (funct3 == F3_B) begin
                merge_d[{addr[1:0], 3'b000} +: 8] = store_data[7:0];
              end else begin
                merge_d[{addr[1], 4'b0000} +: 16] = store_data[15:0];
              end
              addr_d  = aligned_addr;
              state_d = MERGE;
            end
          end
        end
        MERGE: begin
          mem_write_flag = 1'b1;
          mem_addr       = addr_q;
          mem_wdata      = merge_q;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign err_count = err_q;

  // State and data registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      merge_q  <= 32'h0;
      addr_q   <= 32'h0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      merge_q  <= merge_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit with a small
//             word-organised memory model (async read, clocked write).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:15] = '{32'h0000000F, 32'h0000000C, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

  load_store_unit #(.ERR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .is_load        (is_load),
    .is_store       (is_store),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .mem_rdata      (mem_rdata),
    .mem_read_flag  (mem_read_flag),
    .mem_write_flag (mem_write_flag),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .load_data      (load_data),
    .stall          (stall),
    .fault          (fault),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_write_flag) mem[mem_addr[5:2]] <= mem_wdata;
  end

  // Apply a request at the falling edge, then let outputs settle
  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0; store_data = 32'h0;
    #2;
    n_tests++; if (mem_read_flag !== 1'b0) begin n_fail++; $display("FAIL rst_rd_flag: got %b want 0", mem_read_flag); end
    n_tests++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rst_load_data: got %h want 00000000", load_data); end
    n_tests++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst_err_count: got %h want 00", err_count); end
    n_tests++; if ({stall, fault, mem_write_flag} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {stall, fault, mem_write_flag}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (mem_read_flag !== 1'b0) begin n_fail++; $display("FAIL deassert_cycle_rd: got %b want 0", mem_read_flag); end
    @(negedge clk);
    #1;
    n_tests++; if (mem_read_flag !== 1'b1) begin n_fail++; $display("FAIL post_reset_rd: got %b want 1", mem_read_flag); end
    n_tests++; if (load_data !== 32'h0000000F) begin n_fail++; $display("FAIL post_reset_lw0: got %h want 0000000F", load_data); end
    idle();
    n_tests++; if ({mem_read_flag, mem_write_flag, stall, fault} !== 4'b0000) begin n_fail++; $display("FAIL idle_flags: got %b want 0000", {mem_read_flag, mem_write_flag, stall, fault}); end
    n_tests++; if ({load_data, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL idle_data: got %h want 0", {load_data, mem_wdata}); end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    n_tests++; if (load_data !== 32'h0000000F) begin n_fail++; $display("FAIL lb0: got %h want 0000000F", load_data); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb0_stall: got %b want 0", stall); end
    drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    n_tests++; if (load_data !== 32'h0000000C) begin n_fail++; $display("FAIL lw4: got %h want 0000000C", load_data); end
    n_tests++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL lw4_addr: got %h want 00000004", mem_addr); end
  endtask

  task automatic test_store_byte();
    drive(1'b0, 1'b1, 3'b000, 32'h1, 32'h00000080);
    n_tests++; if ({stall, mem_read_flag, mem_write_flag} !== 3'b110) begin n_fail++; $display("FAIL sb_read_phase: got %b want 110", {stall, mem_read_flag, mem_write_flag}); end
    @(negedge clk); #1;
    n_tests++; if ({stall, mem_read_flag, mem_write_flag} !== 3'b001) begin n_fail++; $display("FAIL sb_write_phase: got %b want 001", {stall, mem_read_flag, mem_write_flag}); end
    n_tests++; if (mem_wdata !== 32'h0000800F) begin n_fail++; $display("FAIL sb_wdata: got %h want 0000800F", mem_wdata); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL sb_addr: got %h want 00000000", mem_addr); end
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    n_tests++; if (load_data !== 32'h0000800F) begin n_fail++; $display("FAIL sb_lw0: got %h want 0000800F", load_data); end
    drive(1'b1, 1'b0, 3'b000, 32'h1, 32'h0);
    n_tests++; if (load_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb1: got %h want FFFFFF80", load_data); end
    drive(1'b1, 1'b0, 3'b100, 32'h1, 32'h0);
    n_tests++; if (load_data !== 32'h00000080) begin n_fail++; $display("FAIL lbu1: got %h want 00000080", load_data); end
  endtask

  task automatic test_store_half();
    drive(1'b0, 1'b1, 3'b001, 32'h6, 32'h1234BEEF);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sh_stall: got %b want 1", stall); end
    @(negedge clk); #1;
    n_tests++; if (mem_wdata !== 32'hBEEF000C) begin n_fail++; $display("FAIL sh_wdata: got %h want BEEF000C", mem_wdata); end
    drive(1'b1, 1'b0, 3'b001, 32'h6, 32'h0);
    n_tests++; if (mem[1] !== 32'hBEEF000C) begin n_fail++; $display("FAIL sh_word1: got %h want BEEF000C", mem[1]); end
    n_tests++; if (load_data !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh6: got %h want FFFFBEEF", load_data); end
    drive(1'b1, 1'b0, 3'b101, 32'h6, 32'h0);
    n_tests++; if (load_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL lhu6: got %h want 0000BEEF", load_data); end
  endtask

  task automatic test_faults();
    logic [3:0]  ld_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  st_v [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  f3_v [4] = '{3'b010, 3'b001, 3'b000, 3'b100};
    logic [31:0] a_v  [4] = '{32'h2, 32'h3, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(ld_v[i][0], st_v[i][0], f3_v[i], a_v[i], 32'h5A5A5A5A);
      n_tests++; if ({fault, mem_read_flag, mem_write_flag, stall} !== 4'b1000) begin n_fail++; $display("FAIL fault_case%0d: got %b want 1000", i, {fault, mem_read_flag, mem_write_flag, stall}); end
    end
    idle();
    n_tests++; if (err_count !== 8'd4) begin n_fail++; $display("FAIL err_count4: got %0d want 4", err_count); end
    for (int i = 0; i < 250; i++) drive(1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
    idle();
    n_tests++; if (err_count !== 8'hFE) begin n_fail++; $display("FAIL err_count254: got %h want FE", err_count); end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 3'b010, 32'h2, 32'h0);
    idle();
    n_tests++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL err_count_sat: got %h want FF", err_count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 3'b010, 32'hC, 32'hDEADBEEF);
    n_tests++; if ({mem_write_flag, stall} !== 2'b10 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw12: got wr=%b stall=%b wdata=%h want wr=1 stall=0 wdata=DEADBEEF", mem_write_flag, stall, mem_wdata); end
    drive(1'b0, 1'b1, 3'b000, 32'hC, 32'h00000011);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_sb_stall: got %b want 1", stall); end
    @(negedge clk); #1;
    n_tests++; if (mem_wdata !== 32'hDEADBE11) begin n_fail++; $display("FAIL b2b_wdata: got %h want DEADBE11", mem_wdata); end
    idle();
    n_tests++; if (mem[3] !== 32'hDEADBE11) begin n_fail++; $display("FAIL b2b_word3: got %h want DEADBE11", mem[3]); end
  endtask

  task automatic test_reset_during_merge();
    drive(1'b0, 1'b1, 3'b000, 32'h8, 32'h000000AA);
    @(negedge clk); #1;
    n_tests++; if (mem_write_flag !== 1'b1) begin n_fail++; $display("FAIL rm_merge_wr: got %b want 1", mem_write_flag); end
    rst = 1'b0;
    #1;
    n_tests++; if (mem_write_flag !== 1'b0) begin n_fail++; $display("FAIL rm_wr_drop: got %b want 0", mem_write_flag); end
    n_tests++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rm_err_clear: got %h want 00", err_count); end
    is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    @(negedge clk);
    n_tests++; if (mem[2] !== 32'h0) begin n_fail++; $display("FAIL rm_word2: got %h want 00000000", mem[2]); end
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    n_tests++; if ({mem_read_flag, mem_write_flag, stall} !== 3'b100) begin n_fail++; $display("FAIL rm_idle_state: got %b want 100", {mem_read_flag, mem_write_flag, stall}); end
    n_tests++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rm_lw8: got %h want 00000000", load_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_byte();
    test_store_half();
    test_faults();
    test_back_to_back();
    test_reset_during_merge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
